// File: rtl/fp64_pkg.sv
// Shared types for the APB double-precision fetch block: class codes, FSM states,
// the queued result entry and the IEEE-754 double classifier.
package fp64_pkg;

   localparam int FP64_EXP_W   = 11;
   localparam int FP64_MANT_W  = 52;
   localparam int ENTRY_ADDR_W = 32;

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUB  = 3'd1,
      CLS_INF  = 3'd2,
      CLS_NAN  = 3'd3,
      CLS_NORM = 3'd4,
      CLS_ERR  = 3'd7
   } fp64_class_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_GAP
   } fetch_state_t;

   typedef struct packed {
      logic [63:0]             data;
      logic                    err;
      fp64_class_t             cls;
      logic [ENTRY_ADDR_W-1:0] addr;
   } fp64_entry_t;

   // Sign is deliberately ignored: -0 is ZERO, -inf is INF, and so on.
   function automatic fp64_class_t fp64_classify(input logic [63:0] d);
      logic [FP64_EXP_W-1:0]  e;
      logic [FP64_MANT_W-1:0] m;
      fp64_class_t            c;
      e = d[FP64_MANT_W +: FP64_EXP_W];
      m = d[FP64_MANT_W-1:0];
      if (e == '0)
         c = (m == '0) ? CLS_ZERO : CLS_SUB;
      else if (e == '1)
         c = (m == '0) ? CLS_INF : CLS_NAN;
      else
         c = CLS_NORM;
      return c;
   endfunction

endpackage

// File: rtl/apb_fp64_fetch_if.sv
// Signal bundle around the fetch sequencer: request input, APB master side, result queue.
// Handshake: req_* and out_* move one item on a rising PCLK edge where valid and ready are both high; valid keeps its payload stable until then.
interface apb_fp64_fetch_if #(parameter int ADDR_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;

   logic              PSEL;
   logic              transfer;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic              PREADY;
   logic [31:0]       PRDATA1;
   logic [31:0]       PRDATA2;

   logic              out_valid;
   logic              out_ready;
   logic [63:0]       out_data;
   logic              out_sign;
   logic [10:0]       out_exp;
   logic [51:0]       out_mant;
   logic [2:0]        out_class;
   logic              out_err;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      input  req_valid, req_addr, PREADY, PRDATA1, PRDATA2, out_ready,
      output req_ready, PSEL, transfer, PWRITE, PADDR,
             out_valid, out_data, out_sign, out_exp, out_mant, out_class, out_err, out_addr
   );

   modport slave (
      output req_valid, req_addr, PREADY, PRDATA1, PRDATA2, out_ready,
      input  req_ready, PSEL, transfer, PWRITE, PADDR,
             out_valid, out_data, out_sign, out_exp, out_mant, out_class, out_err, out_addr
   );
endinterface

// File: rtl/fp64_fetch_fifo.sv
// Small synchronous FIFO of fetch result entries; storage resets to zero so the
// head fields read as zero while the queue has never been written.
module fp64_fetch_fifo
   import fp64_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fp64_entry_t              din,
   input  logic                     pop,
   output fp64_entry_t              dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);

   fp64_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];
endmodule

// File: rtl/apb_fp64_fetch.sv
// Read sequencer upstream of an APB master: one read per request, the two 32-bit
// read words are joined into a double, classified and queued with a PREADY timeout.
module apb_fp64_fetch
   import fp64_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                        PCLK,
   input  logic                        PRESETn,
   apb_fp64_fetch_if.master            bus,
   output fetch_state_t                dbg_state,
   output logic [$clog2(FIFO_DEPTH):0] dbg_count
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   fetch_state_t  state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic          push;
   logic          push_err;
   logic          req_ready_c;
   logic          xfer_active;
   fp64_entry_t   push_entry;
   fp64_entry_t   head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         paddr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         paddr_q <= paddr_d;
      end
   end

   // Accepting only when the queue has room means a push can never overflow it,
   // since at most one read is in flight.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      paddr_d     = paddr_q;
      push        = 1'b0;
      push_err    = 1'b0;
      req_ready_c = 1'b0;
      xfer_active = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready_c = !fifo_full;
            if (bus.req_valid && !fifo_full) begin
               paddr_d = bus.req_addr;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            xfer_active = 1'b1;
            cnt_d       = '0;
            state_d     = ST_ACCESS;
         end
         ST_ACCESS: begin
            xfer_active = 1'b1;
            if (bus.PREADY) begin
               push    = 1'b1;
               cnt_d   = '0;
               state_d = ST_GAP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               push     = 1'b1;
               push_err = 1'b1;
               cnt_d    = '0;
               state_d  = ST_GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      push_entry.data = push_err ? 64'd0 : {bus.PRDATA1, bus.PRDATA2};
      push_entry.err  = push_err;
      push_entry.cls  = push_err ? CLS_ERR : fp64_classify({bus.PRDATA1, bus.PRDATA2});
      push_entry.addr = ENTRY_ADDR_W'(paddr_q);
   end

   fp64_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .push  (push),
      .din   (push_entry),
      .pop   (bus.out_ready),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.req_ready = req_ready_c;
   assign bus.PSEL      = xfer_active;
   assign bus.transfer  = xfer_active;
   assign bus.PWRITE    = 1'b0;
   assign bus.PADDR     = paddr_q;

   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = head.data;
   assign bus.out_sign  = head.data[63];
   assign bus.out_exp   = head.data[FP64_MANT_W +: FP64_EXP_W];
   assign bus.out_mant  = head.data[FP64_MANT_W-1:0];
   assign bus.out_class = head.cls;
   assign bus.out_err   = head.err;
   assign bus.out_addr  = ADDR_W'(head.addr);

   assign dbg_state = state_q;
   assign dbg_count = fifo_count;
endmodule

// File: tb/tb_apb_fp64_fetch.sv
// Bench for apb_fp64_fetch: a reactive APB slave, a queue-based model of the result
// stream checked every cycle, directed timing/literal cases and a randomized run.
module tb_apb_fp64_fetch;
   import fp64_pkg::*;

   localparam int TIMEOUT = 16;
   localparam int W       = 100;   // {addr[31:0], err, class[2:0], data[63:0]}

   typedef struct {
      logic [31:0] addr;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      bit          to;
   } plan_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_fp64_fetch_if #(.ADDR_W(32)) bus ();
   fetch_state_t dbg_state;
   logic [1:0]   dbg_count;

   apb_fp64_fetch #(.ADDR_W(32), .FIFO_DEPTH(2), .TIMEOUT(TIMEOUT)) dut (
      .PCLK      (clk),
      .PRESETn   (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_count (dbg_count)
   );

   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] exp_q[$];
   plan_t       plan_q[$];
   plan_t       cur;
   int          k = 0;
   int          ready_mode = 0;   // 0: hold off, 1: always pop, 2: random

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] model_class(input logic [63:0] d);
      if (d[62:52] == 11'h000) return (d[51:0] == 52'd0) ? 3'd0 : 3'd1;
      if (d[62:52] == 11'h7ff) return (d[51:0] == 52'd0) ? 3'd2 : 3'd3;
      return 3'd4;
   endfunction

   function automatic logic [W-1:0] expect_entry(input logic [31:0] addr, input bit to,
                                                 input logic [31:0] hi, input logic [31:0] lo);
      logic [63:0] d;
      d = {hi, lo};
      if (to) return {addr, 1'b1, 3'd7, 64'd0};
      return {addr, 1'b0, model_class(d), d};
   endfunction

   // Slave responder and result-stream scoreboard, evaluated on each falling edge.
   initial begin : monitor
      logic [W-1:0] e;
      bus.PREADY    = 1'b0;
      bus.PRDATA1   = '0;
      bus.PRDATA2   = '0;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            plan_q.delete();
            k             = 0;
            bus.PREADY    = 1'b0;
            bus.out_ready = 1'b0;
         end else begin
            chk("pwrite", 64'(bus.PWRITE), 64'd0);
            if (bus.PSEL) begin
               k++;
               if (k == 1) begin
                  chk("plan_avail", 64'(plan_q.size()), 64'd1);
                  if (plan_q.size() != 0) cur = plan_q.pop_front();
                  bus.PRDATA1 = cur.hi;
                  bus.PRDATA2 = cur.lo;
                  chk("paddr", 64'(bus.PADDR), 64'(cur.addr));
               end
               bus.PREADY = !cur.to && (k >= 2 + cur.lat);
            end else begin
               if (k != 0) begin
                  chk("psel_cycles", 64'(k), cur.to ? 64'(TIMEOUT + 1) : 64'(cur.lat + 2));
                  exp_q.push_back(expect_entry(cur.addr, cur.to, cur.hi, cur.lo));
               end
               k          = 0;
               bus.PREADY = 1'b0;
            end

            case (ready_mode)
               0:       bus.out_ready = 1'b0;
               1:       bus.out_ready = 1'b1;
               default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase

            chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (bus.out_valid && exp_q.size() != 0) begin
               e = exp_q[0];
               chk("out_data",  bus.out_data,         e[63:0]);
               chk("out_class", 64'(bus.out_class),   64'(e[66:64]));
               chk("out_err",   64'(bus.out_err),     64'(e[67]));
               chk("out_addr",  64'(bus.out_addr),    64'(e[99:68]));
               chk("out_sign",  64'(bus.out_sign),    64'(e[63]));
               chk("out_exp",   64'(bus.out_exp),     64'(e[62:52]));
               chk("out_mant",  64'(bus.out_mant),    64'(e[51:0]));
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic [31:0] addr, input logic [31:0] hi, input logic [31:0] lo,
                        input int lat, input bit to);
      plan_t p;
      int    n;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      n = 0;
      while (!bus.req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", 64'(bus.req_ready), 64'd1);
      if (bus.req_ready) begin
         p.addr = addr; p.hi = hi; p.lo = lo; p.lat = lat; p.to = to;
         plan_q.push_back(p);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_valid", 64'(bus.out_valid), 64'd1);
   endtask

   task automatic wait_empty();
      int n = 0;
      while ((bus.out_valid || bus.PSEL || exp_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(bus.out_valid), 64'd0);
   endtask

   task automatic fetch_hold(input logic [31:0] addr, input logic [31:0] hi, input logic [31:0] lo,
                             input int lat, input bit to);
      ready_mode = 0;
      issue(addr, hi, lo, lat, to);
      wait_valid();
   endtask

   task automatic drain();
      ready_mode = 1;
      wait_empty();
      ready_mode = 0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin : main
      logic [31:0] hi, lo, addr;
      int          cat;
      logic        sgn;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_psel",      64'(bus.PSEL),      64'd0);
      chk("rst_transfer",  64'(bus.transfer),  64'd0);
      chk("rst_paddr",     64'(bus.PADDR),     64'd0);
      chk("rst_out_data",  bus.out_data,       64'd0);
      chk("rst_out_class", 64'(bus.out_class), 64'd0);
      chk("rst_out_err",   64'(bus.out_err),   64'd0);
      chk("rst_out_addr",  64'(bus.out_addr),  64'd0);
      chk("rst_state",     64'(dbg_state),     64'(ST_IDLE));

      // First read: cycle-by-cycle timing and literal field values.
      ready_mode = 0;
      issue(32'h4, 32'h400921CA, 32'hC083126F, 0, 1'b0);
      chk("t1_setup_psel",     64'(bus.PSEL),      64'd1);
      chk("t1_setup_transfer", 64'(bus.transfer),  64'd1);
      @(negedge clk);
      chk("t2_access_psel",    64'(bus.PSEL),      64'd1);
      chk("t2_no_valid",       64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("t3_valid",          64'(bus.out_valid), 64'd1);
      chk("t3_psel_low",       64'(bus.PSEL),      64'd0);
      chk("t3_req_ready_low",  64'(bus.req_ready), 64'd0);
      @(negedge clk);
      chk("t4_req_ready",      64'(bus.req_ready), 64'd1);
      chk("lit_data",  bus.out_data,          64'h400921CAC083126F);
      chk("lit_sign",  64'(bus.out_sign),     64'd0);
      chk("lit_exp",   64'(bus.out_exp),      64'h400);
      chk("lit_mant",  64'(bus.out_mant),     64'h921CAC083126F);
      chk("lit_class", 64'(bus.out_class),    64'd4);
      chk("lit_addr",  64'(bus.out_addr),     64'h4);
      drain();

      // Entry held under backpressure for five cycles.
      fetch_hold(32'h8, 32'h4005BEDF, 32'hA43FE5C9, 1, 1'b0);
      repeat (5) @(negedge clk);
      chk("hold_exp",  64'(bus.out_exp),  64'h400);
      chk("hold_mant", 64'(bus.out_mant), 64'h5BEDFA43FE5C9);
      chk("hold_addr", 64'(bus.out_addr), 64'h8);
      drain();

      fetch_hold(32'hC,  32'h00000000, 32'h00000000, 0, 1'b0);
      chk("cls_zero", 64'(bus.out_class), 64'd0);
      drain();
      fetch_hold(32'h10, 32'h00000000, 32'h00000001, 2, 1'b0);
      chk("cls_sub",  64'(bus.out_class), 64'd1);
      drain();
      fetch_hold(32'h14, 32'h7FF00000, 32'h00000000, 0, 1'b0);
      chk("cls_inf",  64'(bus.out_class), 64'd2);
      drain();
      fetch_hold(32'h18, 32'hFFF80000, 32'h00000000, 3, 1'b0);
      chk("cls_nan",  64'(bus.out_class), 64'd3);
      chk("nan_sign", 64'(bus.out_sign),  64'd1);
      drain();

      // Queue full: third request must wait for a pop.
      ready_mode = 0;
      issue(32'h100, 32'h3FF00000, 32'h00000000, 0, 1'b0);
      issue(32'h104, 32'h40000000, 32'h00000000, 1, 1'b0);
      repeat (6) @(negedge clk);
      chk("full_req_ready", 64'(bus.req_ready), 64'd0);
      chk("full_count",     64'(dbg_count),     64'd2);
      chk("full_head_addr", 64'(bus.out_addr),  64'h100);
      ready_mode = 1;
      issue(32'h108, 32'h40080000, 32'h00000000, 0, 1'b0);
      wait_empty();
      ready_mode = 0;

      // PREADY never arrives.
      fetch_hold(32'h200, 32'h12345678, 32'h9ABCDEF0, 0, 1'b1);
      chk("to_err",   64'(bus.out_err),   64'd1);
      chk("to_class", 64'(bus.out_class), 64'd7);
      chk("to_data",  bus.out_data,       64'd0);
      chk("to_psel",  64'(bus.PSEL),      64'd0);
      drain();

      // Reset during ACCESS with one entry queued.
      fetch_hold(32'h300, 32'h3FF80000, 32'h00000000, 0, 1'b0);
      issue(32'h304, 32'h40100000, 32'h00000000, 10, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_psel",     64'(bus.PSEL),      64'd0);
      chk("mid_rst_transfer", 64'(bus.transfer),  64'd0);
      chk("mid_rst_valid",    64'(bus.out_valid), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      fetch_hold(32'h308, 32'hC0240000, 32'h00000000, 1, 1'b0);
      chk("post_rst_addr",  64'(bus.out_addr),  64'h308);
      chk("post_rst_class", 64'(bus.out_class), 64'd4);
      drain();

      // Randomized traffic with random consumer backpressure.
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
         cat  = $urandom_range(0, 5);
         sgn  = 1'($urandom_range(0, 1));
         addr = $urandom & 32'hFFFF_FFFC;
         case (cat)
            0:       begin hi = {sgn, 31'd0};                          lo = 32'd0; end
            1:       begin hi = {sgn, 11'h000, 20'($urandom)};         lo = $urandom | 32'd1; end
            2:       begin hi = {sgn, 11'h7ff, 20'd0};                 lo = 32'd0; end
            3:       begin hi = {sgn, 11'h7ff, 20'($urandom)};         lo = $urandom | 32'd1; end
            default: begin hi = $urandom;                              lo = $urandom; end
         endcase
         issue(addr, hi, lo, $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      end
      wait_empty();
      ready_mode = 0;
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
